ddram_nport_arbiter: RTL and testbench

Parametrised N-channel arbiter that multiplexes independent single-word read/write requesters (microcode, main memory, CPU VRAM, VGA VRAM, ...) onto the MiSTer DDRAM Avalon-style port. It generalises the fixed four-client RAM controller to NCH channels with a selectable fixed-priority or round-robin grant policy. It keeps one transaction outstanding at a time, always uses burst count 1, and returns per-channel completion pulses.

---
 rtl/ddram_nport_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddram_nport_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_nport_arbiter.sv
// N-channel single-word arbiter onto the MiSTer DDRAM Avalon port, fixed-priority or round-robin.
// Optional read watchdog enabled by defining DDRAM_ARB_TIMEOUT_EN.
module ddram_nport_arbiter #(
  parameter int NCH            = 4,
  parameter int AW             = 29,
  parameter int DW             = 64,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_write,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*DW-1:0]     req_wdata,
  input  logic [NCH*DW/8-1:0]   req_be,
  output logic [NCH-1:0]        rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [2:0]            grant_id,
  output logic                  err_timeout,
  output logic                  DDRAM_CLK,
  input  logic                  DDRAM_BUSY,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic [AW-1:0]         DDRAM_ADDR,
  input  logic [DW-1:0]         DDRAM_DOUT,
  input  logic                  DDRAM_DOUT_READY,
  output logic                  DDRAM_RD,
  output logic [DW-1:0]         DDRAM_DIN,
  output logic [DW/8-1:0]       DDRAM_BE,
  output logic                  DDRAM_WE
);

  localparam int BW  = DW / 8;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DDRAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        grant_reg;
  logic [2:0]        rr_ptr_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     din_reg;
  logic [BW-1:0]     be_reg;
  logic              wr_reg;
  logic [DW-1:0]     rdata_reg;
  logic [NCH-1:0]    rsp_valid_reg, rsp_next;
  logic              err_reg;
  logic [TCW-1:0]    to_cnt_reg;

  // Channels are padded out to 8 so a 3-bit index always addresses cleanly
  logic [7:0]        req_pad, write_pad;
  logic [AW-1:0]     addr_arr  [8];
  logic [DW-1:0]     wdata_arr [8];
  logic [BW-1:0]     be_arr    [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NCH) begin : g_live
        assign req_pad[gi]   = req_valid[gi];
        assign write_pad[gi] = req_write[gi];
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        assign be_arr[gi]    = req_be[gi*BW +: BW];
      end else begin : g_pad
        assign req_pad[gi]   = 1'b0;
        assign write_pad[gi] = 1'b0;
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign be_arr[gi]    = '0;
      end
    end
  endgenerate

  logic       win_found;
  logic [2:0] win_idx, scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NCH; k++) begin
        scan_idx = 3'((int'(rr_ptr_reg) + k) % NCH);
        if (!win_found && req_pad[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req_pad[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  // Arbitration is held off while the completion pulse is out, so a request
  // still high in that cycle cannot be served a second time.
  logic arb_go, to_hit;
  assign arb_go = (state_reg == IDLE) && win_found && (rsp_valid_reg == '0);
  assign to_hit = TO_EN && (state_reg == WAIT_RD) && !DDRAM_DOUT_READY &&
                  (to_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_go) state_next = ISSUE;
      ISSUE:   if (!DDRAM_BUSY) state_next = wr_reg ? DONE : WAIT_RD;
      WAIT_RD: if (DDRAM_DOUT_READY || to_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_next = '0;
    for (int i = 0; i < NCH; i++)
      rsp_next[i] = (state_reg == DONE) && (grant_reg == 3'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg     <= '0;
      rr_ptr_reg    <= 3'(NCH - 1);
      addr_reg      <= '0;
      din_reg       <= '0;
      be_reg        <= '0;
      wr_reg        <= 1'b0;
      rdata_reg     <= '0;
      rsp_valid_reg <= '0;
      err_reg       <= 1'b0;
      to_cnt_reg    <= '0;
    end else begin
      rsp_valid_reg <= rsp_next;
      if (arb_go) begin
        grant_reg <= win_idx;
        addr_reg  <= addr_arr[win_idx];
        din_reg   <= wdata_arr[win_idx];
        be_reg    <= be_arr[win_idx];
        wr_reg    <= write_pad[win_idx];
      end
      if (state_reg == WAIT_RD) begin
        if (DDRAM_DOUT_READY) begin
          rdata_reg <= DDRAM_DOUT;
        end else if (to_hit) begin
          rdata_reg <= {DW/32{32'hDEAD_BEEF}};
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == DONE && RR_MODE != 0) rr_ptr_reg <= grant_reg;
      to_cnt_reg <= (TO_EN && state_reg == WAIT_RD) ? to_cnt_reg + TCW'(1) : '0;
    end
  end

  assign rsp_valid      = rsp_valid_reg;
  assign rsp_rdata      = rdata_reg;
  assign grant_id       = grant_reg;
  assign err_timeout    = err_reg;
  assign DDRAM_CLK      = clk;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = addr_reg;
  assign DDRAM_DIN      = din_reg;
  assign DDRAM_BE       = be_reg;
  assign DDRAM_RD       = (state_reg == ISSUE) && !wr_reg;
  assign DDRAM_WE       = (state_reg == ISSUE) && wr_reg;

endmodule

// File: tb/tb_ddram_nport_arbiter.sv
// Directed bench for ddram_nport_arbiter: a vector table through a DDRAM model plus
// hand sequences for BUSY stall, RR/fixed-priority ordering, reset in WAIT_RD and timeout.
module tb_ddram_nport_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 29;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_valid = '0, req_valid_fp = '0, req_write = '0;
  logic [NCH*AW-1:0] req_addr  = '0;
  logic [NCH*DW-1:0] req_wdata = '0;
  logic [NCH*BW-1:0] req_be    = '0;

  logic [NCH-1:0] rsp_valid, rsp_valid_fp;
  logic [DW-1:0]  rsp_rdata, rsp_rdata_fp;
  logic [2:0]     grant_id, grant_fp;
  logic           err_timeout, err_fp;
  logic           ddr_clk, ddr_clk_fp;
  logic           DDRAM_BUSY = 1'b0, DDRAM_DOUT_READY = 1'b0;
  logic [DW-1:0]  DDRAM_DOUT = '0;
  logic [7:0]     ddr_burst, ddr_burst_fp;
  logic [AW-1:0]  ddr_addr, ddr_addr_fp;
  logic           ddr_rd, ddr_we, ddr_rd_fp, ddr_we_fp;
  logic [DW-1:0]  ddr_din, ddr_din_fp;
  logic [BW-1:0]  ddr_be, ddr_be_fp;
  logic           zero_bit = 1'b0;
  logic [DW-1:0]  zero_word = '0;

  ddram_nport_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .grant_id(grant_id), .err_timeout(err_timeout),
    .DDRAM_CLK(ddr_clk), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(ddr_burst),
    .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din), .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we));

  // Fixed-priority instance, write-only traffic, memory side always ready
  ddram_nport_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT_CYCLES(255)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid_fp), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_fp), .rsp_rdata(rsp_rdata_fp), .grant_id(grant_fp), .err_timeout(err_fp),
    .DDRAM_CLK(ddr_clk_fp), .DDRAM_BUSY(zero_bit), .DDRAM_BURSTCNT(ddr_burst_fp),
    .DDRAM_ADDR(ddr_addr_fp), .DDRAM_DOUT(zero_word), .DDRAM_DOUT_READY(zero_bit),
    .DDRAM_RD(ddr_rd_fp), .DDRAM_DIN(ddr_din_fp), .DDRAM_BE(ddr_be_fp), .DDRAM_WE(ddr_we_fp));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // DDRAM model: commands accepted when BUSY is low; read data after rd_lat cycles (0 = never)
  logic [DW-1:0] mem [logic [AW-1:0]];
  int rd_lat = 4;
  int rd_pend = 0;
  int beats = 0;
  int rsp_pulses = 0;
  logic [DW-1:0] rd_val = '0;

  always @(negedge clk) begin
    logic [DW-1:0] tmp;
    DDRAM_DOUT_READY = 1'b0;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = rd_val;
      end
    end
    if (!DDRAM_BUSY && !reset) begin
      if (ddr_we) begin
        beats++;
        tmp = mem.exists(ddr_addr) ? mem[ddr_addr] : '0;
        for (int b = 0; b < BW; b++)
          if (ddr_be[b]) tmp[b*8 +: 8] = ddr_din[b*8 +: 8];
        mem[ddr_addr] = tmp;
      end
      if (ddr_rd) begin
        rd_val = mem.exists(ddr_addr) ? mem[ddr_addr] : '0;
        rd_pend = rd_lat;
      end
    end
    if (rsp_valid != '0) rsp_pulses++;
  end

  // One transaction on the RR instance; called and returns at posedge+1
  task automatic do_txn(input int ch, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be, input int lat,
                        input int budget, output int cycles, output logic [NCH-1:0] seen,
                        output logic [NCH-1:0] after, output logic [2:0] gid, output int bdelta);
    int b0;
    b0 = beats;
    rd_lat = lat;
    req_addr[ch*AW +: AW] = addr;
    req_wdata[ch*DW +: DW] = wd;
    req_be[ch*BW +: BW] = be;
    req_write[ch] = wr;
    req_valid[ch] = 1'b1;
    cycles = 0;
    seen = '0;
    gid = '0;
    while (cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (rsp_valid != '0) begin
        seen = rsp_valid;
        gid = grant_id;
        break;
      end
    end
    req_valid[ch] = 1'b0;
    @(posedge clk); #1;
    after = rsp_valid;
    bdelta = beats - b0;
  endtask

  int quota[NCH];
  int got_order[8];

  // Continuous traffic: each channel drops req in its rsp cycle and re-raises next cycle
  task automatic run_traffic(input bit fp, input int n);
    int remaining[NCH];
    logic [NCH-1:0] pend, rsp, reqv;
    int ng, cyc, g;
    reqv = '0;
    for (int i = 0; i < NCH; i++) begin
      remaining[i] = quota[i];
      reqv[i] = (quota[i] > 0);
      req_addr[i*AW +: AW] = AW'(29'h500 + i);
      req_wdata[i*DW +: DW] = DW'(i);
      req_be[i*BW +: BW] = '1;
    end
    for (int k = 0; k < 8; k++) got_order[k] = -1;
    req_write = '1;
    if (fp) req_valid_fp = reqv; else req_valid = reqv;
    ng = 0; cyc = 0; pend = '0;
    while (ng < n && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      rsp  = fp ? rsp_valid_fp : rsp_valid;
      reqv = (fp ? req_valid_fp : req_valid) | pend;
      pend = '0;
      if (rsp != '0) begin
        g = 0;
        for (int i = 0; i < NCH; i++) if (rsp[i]) g = i;
        got_order[ng] = g;
        ng++;
        remaining[g]--;
        reqv[g] = 1'b0;
        if (remaining[g] > 0) pend[g] = 1'b1;
      end
      if (fp) req_valid_fp = reqv; else req_valid = reqv;
    end
    req_valid = '0;
    req_valid_fp = '0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int            ch;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            lat;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc, bd, p0, nz;
    logic [NCH-1:0] seen, after;
    logic [2:0] gid;
    logic [DW-1:0] last_read;
    logic [NCH-1:0] one;
    int exp_rr[8];
    int exp_fp[6];
    bit stable;

    vecs[0] = '{2, 1'b1, 29'h100, 64'h0123_4567_89AB_CDEF, 8'hFF, 4, 64'h0, 3};
    vecs[1] = '{2, 1'b0, 29'h100, 64'h0, 8'h00, 4, 64'h0123_4567_89AB_CDEF, 7};
    vecs[2] = '{1, 1'b1, 29'h200, 64'h0, 8'hFF, 4, 64'h0, 3};
    vecs[3] = '{1, 1'b1, 29'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4, 64'h0, 3};
    vecs[4] = '{3, 1'b0, 29'h200, 64'h0, 8'h00, 4, 64'h0000_0000_FFFF_FFFF, 7};
    vecs[5] = '{0, 1'b1, 29'h100, 64'h0, 8'h00, 4, 64'h0, 3};
    vecs[6] = '{0, 1'b0, 29'h100, 64'h0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 4};
    vecs[7] = '{3, 1'b1, 29'h300, 64'hAAAA_5555_AAAA_5555, 8'hFF, 4, 64'h0, 3};
    vecs[8] = '{2, 1'b0, 29'h300, 64'h0, 8'h00, 2, 64'hAAAA_5555_AAAA_5555, 5};
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_fp = '{0, 0, 1, 1, 2, 3};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_cmd_rd_we", {62'h0, ddr_rd, ddr_we}, 64'h0);
    chk("reset_burstcnt", 64'(ddr_burst), 64'h1);
    chk("reset_addr_din_be", {27'h0, ddr_addr, ddr_be} | ddr_din, 64'h0);
    chk("reset_rdata_grant_err", rsp_rdata | 64'(grant_id) | 64'(err_timeout), 64'h0);

    // Round-robin ordering, straight out of reset
    for (int i = 0; i < NCH; i++) quota[i] = 2;
    run_traffic(1'b0, 8);
    for (int k = 0; k < 8; k++) begin
      $display("rr txn %0d: channel %0d", k, got_order[k]);
      chk($sformatf("rr_order_%0d", k), 64'(got_order[k]), 64'(exp_rr[k]));
    end

    // Fixed priority: channel 3 only after channels 0-2 go idle
    quota[0] = 2; quota[1] = 2; quota[2] = 1; quota[3] = 1;
    run_traffic(1'b1, 6);
    for (int k = 0; k < 6; k++) begin
      $display("fp txn %0d: channel %0d", k, got_order[k]);
      chk($sformatf("fp_order_%0d", k), 64'(got_order[k]), 64'(exp_fp[k]));
    end

    last_read = rsp_rdata;
    for (int v = 0; v < 9; v++) begin
      do_txn(vecs[v].ch, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be,
             vecs[v].lat, 100, cyc, seen, after, gid, bd);
      one = '0;
      one[vecs[v].ch] = 1'b1;
      $display("vec %0d: ch=%0d wr=%0d addr=%h rsp=%b lat=%0d rdata=%h",
               v, vecs[v].ch, vecs[v].wr, vecs[v].addr, seen, cyc, rsp_rdata);
      chk($sformatf("v%0d_rsp_onehot", v), 64'(seen), 64'(one));
      chk($sformatf("v%0d_pulse_one_cycle", v), 64'(after), 64'h0);
      chk($sformatf("v%0d_grant_id", v), 64'(gid), 64'(vecs[v].ch));
      chk($sformatf("v%0d_latency", v), 64'(cyc), 64'(vecs[v].exp_lat));
      chk($sformatf("v%0d_write_beats", v), 64'(bd), vecs[v].wr ? 64'h1 : 64'h0);
      if (vecs[v].wr) begin
        chk($sformatf("v%0d_rdata_held", v), rsp_rdata, last_read);
      end else begin
        chk($sformatf("v%0d_rdata", v), rsp_rdata, vecs[v].exp_rdata);
        last_read = vecs[v].exp_rdata;
      end
    end

    // BUSY held for 5 cycles during a ch0 write
    p0 = rsp_pulses;
    bd = beats;
    DDRAM_BUSY = 1'b1;
    req_addr[0 +: AW] = 29'h400;
    req_wdata[0 +: DW] = 64'h5555_AAAA_1234_5678;
    req_be[0 +: BW] = 8'hFF;
    req_write[0] = 1'b1;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) DDRAM_BUSY = 1'b0;
      if (!(ddr_we && ddr_addr == 29'h400 && ddr_din == 64'h5555_AAAA_1234_5678 && ddr_be == 8'hFF))
        stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_cmd_stable_6_cycles", 64'(stable), 64'h1);
    chk("busy_we_dropped", 64'(ddr_we), 64'h0);
    seen = '0;
    for (int k = 0; k < 10 && seen == '0; k++) begin
      if (rsp_valid != '0) seen = rsp_valid;
      else begin @(posedge clk); #1; end
    end
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("busy write: rsp=%b beats=%0d pulses=%0d", seen, beats - bd, rsp_pulses - p0);
    chk("busy_rsp", 64'(seen), 64'h1);
    chk("busy_beats", 64'(beats - bd), 64'h1);
    chk("busy_pulses", 64'(rsp_pulses - p0), 64'h1);

    // Reset in WAIT_RD, then the late DOUT_READY must be ignored
    rd_lat = 10;
    req_addr[1*AW +: AW] = 29'h100;
    req_write[1] = 1'b0;
    req_valid[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_drops_cmd", {62'h0, ddr_rd, ddr_we}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    nz = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) nz++;
    end
    $display("reset in WAIT_RD: rsp cycles after reset=%0d", nz);
    chk("rst_no_rsp", 64'(nz), 64'h0);
    chk("rst_rdata_cleared", rsp_rdata, 64'h0);
    do_txn(1, 1'b0, 29'h100, 64'h0, 8'h00, 4, 100, cyc, seen, after, gid, bd);
    $display("post-reset read: rsp=%b lat=%0d rdata=%h", seen, cyc, rsp_rdata);
    chk("rst_next_rsp", 64'(seen), 64'h2);
    chk("rst_next_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("rst_next_latency", 64'(cyc), 64'h7);

`ifdef DDRAM_ARB_TIMEOUT_EN
    do_txn(0, 1'b0, 29'h100, 64'h0, 8'h00, 0, 400, cyc, seen, after, gid, bd);
    $display("timeout read: rsp=%b cycles=%0d rdata=%h err=%0d", seen, cyc, rsp_rdata, err_timeout);
    chk("to_rsp", 64'(seen), 64'h1);
    chk("to_rdata", rsp_rdata, 64'hDEADBEEF_DEADBEEF);
    chk("to_err", 64'(err_timeout), 64'h1);
`else
    chk("err_timeout_tied_low", 64'(err_timeout), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
